rle_dec: RTL and testbench

Run-length decoder, the receive-side counterpart of `rle_enc`.
- Pops 24-bit run tokens from an input FIFO and expands each token into its run of identical bits.
- Packs the bits MSB-first into bytes and pushes each completed byte into an output FIFO.
- Sits between the compressed-token FIFO and the byte-sink FIFO; on end of stream it flushes any partial byte and signals completion.

---
 rtl/rle_pkg.sv | 26 ++
 rtl/rle_byte_packer.sv | 36 +++
 rtl/rle_dec.sv | 110 +++++++++++
 tb/tb_rle_dec.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared run-length token format and decoder state encoding
package rle_pkg;

    localparam int TOKEN_W = 24;
    localparam int CNT_W   = 23;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        EXPAND,
        WRITE,
        FLUSH,
        DONE
    } dec_state_t;

    function automatic logic tok_val(input logic [TOKEN_W-1:0] tok);
        return tok[TOKEN_W-1];
    endfunction

    function automatic logic [CNT_W-1:0] tok_len(input logic [TOKEN_W-1:0] tok);
        return tok[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// rtl/rle_byte_packer.sv - MSB-first bit accumulator with left-aligned partial-byte output
module rle_byte_packer
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              bit_in,
    input  logic              clr,
    input  logic              pad,
    output logic              byte_full,
    output logic [3:0]        bit_cnt,
    output logic [BYTE_W-1:0] byte_out
);

    logic [BYTE_W-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {shreg[BYTE_W-2:0], bit_in};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // High on the shift that completes the byte, so the FSM can go straight to WRITE.
    assign byte_full = shift_en && (bit_cnt == 4'(BYTE_W - 1));

    assign byte_out = pad ? (shreg << (4'(BYTE_W) - bit_cnt)) : shreg;

endmodule

// File: rtl/rle_dec.sv
// rtl/rle_dec.sv - run-length token decoder packing expanded bits into bytes
module rle_dec
    import rle_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               recv_ready,
    input  logic [TOKEN_W-1:0] in_data,
    input  logic               end_of_stream,
    output logic               rd_req,
    input  logic               send_ready,
    output logic [BYTE_W-1:0]  out_data,
    output logic               wr_req,
    output logic               done
);

    dec_state_t        state, next_state;
    logic [CNT_W-1:0]  run_len;
    logic              run_val;

    logic              shift_en;
    logic              clr;
    logic              pad;
    logic              push;
    logic              byte_full;
    logic [3:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_out;

    rle_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .bit_in   (run_val),
        .clr      (clr),
        .pad      (pad),
        .byte_full(byte_full),
        .bit_cnt  (bit_cnt),
        .byte_out (byte_out)
    );

    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        clr        = 1'b0;
        pad        = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (recv_ready)
                    next_state = READ;
                else if (end_of_stream)
                    next_state = (bit_cnt != 4'd0) ? FLUSH : DONE;
            end
            READ: next_state = LOAD;
            LOAD: next_state = (tok_len(in_data) == '0) ? IDLE : EXPAND;
            EXPAND: begin
                shift_en = 1'b1;
                if (byte_full)
                    next_state = WRITE;
                else if (run_len == CNT_W'(1))
                    next_state = IDLE;
            end
            WRITE: begin
                if (send_ready) begin
                    push       = 1'b1;
                    clr        = 1'b1;
                    next_state = (run_len != '0) ? EXPAND : IDLE;
                end
            end
            FLUSH: begin
                pad = 1'b1;
                if (send_ready) begin
                    push       = 1'b1;
                    clr        = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            run_len  <= '0;
            run_val  <= 1'b0;
            rd_req   <= 1'b0;
            wr_req   <= 1'b0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            state  <= next_state;
            // The pop strobe coincides with the READ cycle; data is captured in LOAD.
            rd_req <= (next_state == READ);
            wr_req <= push;
            if (push)
                out_data <= byte_out;
            if (state == LOAD) begin
                run_val <= tok_val(in_data);
                run_len <= tok_len(in_data);
            end else if (shift_en && run_len != '0) begin
                run_len <= run_len - CNT_W'(1);
            end
            if (state == DONE)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rle_dec.sv
// tb/tb_rle_dec.sv - scoreboard bench for rle_dec with FIFO models and a bit-level reference
module tb_rle_dec;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        recv_ready = 1'b0;
    logic [23:0] in_data = '0;
    logic        end_of_stream = 1'b0;
    logic        rd_req;
    logic        send_ready = 1'b1;
    logic [7:0]  out_data;
    logic        wr_req;
    logic        done;

    always #5 clk = ~clk;

    rle_dec dut (
        .clk          (clk),
        .rst          (rst),
        .recv_ready   (recv_ready),
        .in_data      (in_data),
        .end_of_stream(end_of_stream),
        .rd_req       (rd_req),
        .send_ready   (send_ready),
        .out_data     (out_data),
        .wr_req       (wr_req),
        .done         (done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sr_mode = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int ntok = 0;
    int first_rd = -1;
    int wr_times[$];
    logic [23:0] tok_q[$];
    logic [7:0]  exp_q[$];
    bit          pend = 1'b0;
    bit          prev_rd = 1'b0;
    bit          prev_wr = 1'b0;
    logic [23:0] held = '0;
    bit          bits_q[$];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Input FIFO, output FIFO and monitor, all sampled mid-cycle.
    always @(negedge clk) begin
        if (pend) begin
            in_data = held;
            pend = 1'b0;
        end else begin
            in_data = 24'($urandom);
        end
        if (rd_req) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            chk("rd_req back-to-back", int'(prev_rd), 0);
            if (tok_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_req on empty input fifo: cycle %0d", cyc);
            end else begin
                held = tok_q.pop_front();
                pend = 1'b1;
            end
        end
        recv_ready = (tok_q.size() != 0);
        case (sr_mode)
            0:       send_ready = 1'b1;
            1:       send_ready = ($urandom_range(0, 9) < 7);
            default: send_ready = 1'b0;
        endcase
        if (wr_req) begin
            wr_cnt++;
            wr_times.push_back(cyc);
            chk("wr_req back-to-back", int'(prev_wr), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected push: got 0x%0h with empty scoreboard", out_data);
            end else begin
                chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
        prev_rd = rd_req;
        prev_wr = wr_req;
    end

    // Reference: expand tokens into a flat bit list; every 8 bits form a byte, MSB first.
    task automatic model_bits_to_bytes(input bit final_flush);
        logic [7:0] b;
        while (bits_q.size() >= 8) begin
            b = '0;
            for (int i = 0; i < 8; i++) b[7-i] = bits_q.pop_front();
            exp_q.push_back(b);
        end
        if (final_flush && bits_q.size() > 0) begin
            b = '0;
            for (int i = 0; bits_q.size() > 0; i++) b[7-i] = bits_q.pop_front();
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [23:0] tok);
        for (int i = 0; i < int'(tok[22:0]); i++) bits_q.push_back(tok[23]);
        model_bits_to_bytes(1'b0);
        tok_q.push_back(tok);
        recv_ready = 1'b1;
        ntok++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        end_of_stream = 1'b0;
        tok_q.delete();
        exp_q.delete();
        bits_q.delete();
        pend = 1'b0;
        recv_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_req", int'(rd_req), 0);
        chk("reset wr_req", int'(wr_req), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset done", int'(done), 0);
        rst = 1'b1;
        rd_cnt = 0;
        wr_cnt = 0;
        ntok = 0;
        first_rd = -1;
        wr_times.delete();
    endtask

    task automatic finish_stream();
        int i;
        end_of_stream = 1'b1;
        model_bits_to_bytes(1'b1);
        for (i = 0; i < 20000 && !done; i++) @(posedge clk);
        #1;
        chk("done", int'(done), 1);
        chk("missing pushes", exp_q.size(), 0);
        chk("rd_req count", rd_cnt, ntok);
    endtask

    initial begin
        do_reset();

        // Runs 2/4/2 fill exactly one byte: no flush push.
        send(24'h000002); send(24'h800004); send(24'h000002);
        finish_stream();
        chk("single push count", wr_cnt, 1);

        // 16 ones: first push 11 cycles after rd_req, second 9 cycles later.
        do_reset();
        send(24'h800010);
        finish_stream();
        chk("ff push count", wr_times.size(), 2);
        if (wr_times.size() >= 2) begin
            chk("rd to first push", wr_times[0] - first_rd, 11);
            chk("push spacing", wr_times[1] - wr_times[0], 9);
        end

        // Run crossing a byte boundary.
        do_reset();
        send(24'h000003); send(24'h800007); send(24'h000006);
        finish_stream();
        chk("boundary push count", wr_cnt, 2);

        // Partial byte flushed; later tokens are ignored.
        do_reset();
        send(24'h800003);
        finish_stream();
        chk("flush push count", wr_cnt, 1);
        tok_q.push_back(24'h800008);
        recv_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rd_req after done", rd_cnt, ntok);
        chk("done sticky", int'(done), 1);

        // Zero-length token consumed with no bits.
        do_reset();
        send(24'h000004); send(24'h800000); send(24'h800004);
        finish_stream();
        chk("zero-len push count", wr_cnt, 1);

        // Backpressure holds the byte in WRITE.
        do_reset();
        sr_mode = 2;
        send(24'h800005); send(24'h000003);
        repeat (25) @(posedge clk);
        #1;
        chk("push under backpressure", wr_cnt, 0);
        sr_mode = 0;
        finish_stream();
        chk("backpressure push count", wr_cnt, 1);

        // Reset in the middle of a long run, then a fresh stream.
        do_reset();
        send(24'h800100);
        for (int i = 0; i < 50 && rd_cnt == 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        do_reset();
        send(24'h000001); send(24'h800002); send(24'h000009);
        finish_stream();

        // Randomized streams with random backpressure.
        sr_mode = 1;
        for (int s = 0; s < 8; s++) begin
            int n;
            logic [23:0] t;
            do_reset();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                t = '0;
                t[23] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 9))
                    0:       t[22:0] = '0;
                    1, 2:    t[22:0] = 23'($urandom_range(11, 40));
                    default: t[22:0] = 23'($urandom_range(1, 10));
                endcase
                send(t);
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
            finish_stream();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
